// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider.
//   DEF_WIDTH : width of the divisor, quotient and remainder (the dividend is twice this)
//   CNT_W     : width of the iteration counter
//   state_t   : controller state encoding
package div_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    FIX,
    DONE
  } state_t;
endpackage

// File: rtl/signed_divider_if.sv
// Handshake bundle for the signed divider.
//   request  : in_valid, in_ready, dividend (2*WIDTH bits), divisor (WIDTH bits)
//   response : out_valid, out_ready, quotient, remainder, div_zero, overflow
// The master modport is the requester/consumer side. The slave modport is the divider side.
interface signed_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_zero;
  logic                 overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/div_step.sv
// One restoring division iteration. This block is purely combinational.
//   rem_in  : partial remainder, always less than dvs
//   bit_in  : next dividend bit that is shifted in
//   dvs     : divisor magnitude
//   rem_out : updated partial remainder
//   q_bit   : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The dvs magnitude is at most 2^(WIDTH-1), so rem_in < 2^(WIDTH-1).
  // That keeps 'shifted' below 2^WIDTH, and diff[WIDTH] is therefore a true sign bit.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, dvs};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/signed_divider.sv
// Iterative signed divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit divisor.
// It produces a quotient truncated toward zero and a remainder that takes the sign of the dividend.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active HIGH (the name is inherited)
//   bus   : request/response handshake (signed_divider_if.slave)
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// PREP  | form magnitudes and signs, pre-check divide-by-zero and wide overflow
// DIV   | WIDTH restoring iterations
// FIX   | narrow overflow check, apply signs
// DONE  | out_valid high, waiting for out_ready
module signed_divider
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  signed_divider_if.slave bus
);
  localparam int WIDTH = DEF_WIDTH;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH-1:0]   abs_dvs;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   low_r;
  logic [CNT_W-1:0]   cnt;
  logic               q_neg;
  logic               r_neg;
  logic               early;

  logic [2*WIDTH-1:0] abs_dvd_c;
  logic [WIDTH-1:0]   abs_dvs_c;
  logic               pre_exc;
  logic               q_over;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (low_r[WIDTH-1]),
    .dvs     (abs_dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    abs_dvd_c = dvd_r[2*WIDTH-1] ? -dvd_r : dvd_r;
    abs_dvs_c = dvs_r[WIDTH-1] ? -dvs_r : dvs_r;
    pre_exc   = (dvs_r == '0) || (abs_dvd_c[2*WIDTH-1:WIDTH] >= abs_dvs_c);
    // A negative result may reach -2^(WIDTH-1). A positive result must stay below 2^(WIDTH-1).
    q_over    = q_neg ? (low_r > {1'b1, {(WIDTH-1){1'b0}}}) : low_r[WIDTH-1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid && bus.in_ready) state_nxt = PREP;
      // Exceptions detected in PREP still pass through FIX.
      // This keeps their latency at two edges. FIX leaves their outputs untouched.
      PREP: state_nxt = pre_exc ? FIX : DIV;
      DIV:  if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.in_ready  <= (state_nxt == IDLE);
      bus.out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: if (bus.in_valid && bus.in_ready) begin
          dvd_r        <= bus.dividend;
          dvs_r        <= bus.divisor;
          bus.div_zero <= 1'b0;
          bus.overflow <= 1'b0;
        end
        PREP: begin
          q_neg   <= dvd_r[2*WIDTH-1] ^ dvs_r[WIDTH-1];
          r_neg   <= dvd_r[2*WIDTH-1];
          abs_dvs <= abs_dvs_c;
          rem_r   <= abs_dvd_c[2*WIDTH-1:WIDTH];
          low_r   <= abs_dvd_c[WIDTH-1:0];
          cnt     <= '0;
          early   <= pre_exc;
          if (pre_exc) begin
            bus.div_zero  <= (dvs_r == '0);
            bus.overflow  <= (dvs_r != '0);
            bus.quotient  <= '0;
            bus.remainder <= '0;
          end
        end
        DIV: begin
          rem_r <= step_rem;
          low_r <= {low_r[WIDTH-2:0], step_q};
          cnt   <= cnt + 1'b1;
        end
        FIX: if (!early) begin
          if (q_over) begin
            bus.overflow  <= 1'b1;
            bus.quotient  <= '0;
            bus.remainder <= '0;
          end else begin
            bus.quotient  <= q_neg ? -low_r : low_r;
            bus.remainder <= r_neg ? -rem_r : rem_r;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
